tt_um_jleugeri_ttt_host_driver: RTL and testbench

//  Host-side counterpart of the TTT main controller's execution interface. Converts a ready/valid stream
//  of external input events into the main controller's instruction protocol (read-input 4'b0001, advance
//  4'b0010, block 4'b0000), tracks the controller's stage, captures every emitted start/stop token into an

---
 rtl/tt_um_jleugeri_ttt_pkg.sv | 26 ++
 rtl/tt_um_jleugeri_ttt_event_fifo.sv | 52 +++++
 rtl/tt_um_jleugeri_ttt_host_driver.sv | 170 +++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_host_driver.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared definitions for the TTT main controller and its host-side driver:
// instruction opcodes, controller stage encoding, start/stop token encodings.
package tt_um_jleugeri_ttt_pkg;

  localparam logic [3:0] INSTR_BLOCK   = 4'b0000;
  localparam logic [3:0] INSTR_READ    = 4'b0001;
  localparam logic [3:0] INSTR_ADVANCE = 4'b0010;

  localparam logic [1:0] SS_START = 2'b10;
  localparam logic [1:0] SS_STOP  = 2'b01;

  typedef enum logic [1:0] {
    STAGE_INPUT  = 2'b00,
    STAGE_UPDATE = 2'b01,
    STAGE_SCAN   = 2'b10,
    STAGE_ROUTE  = 2'b11
  } stage_t;

  typedef enum logic [1:0] {
    StFeed,
    StAdvance,
    StWaitLeave,
    StRun
  } drv_state_t;

endpackage

// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Synchronous FIFO with extra-wrap-bit pointers; a push while full (and not popping)
// is dropped and raises a sticky overflow flag.
module tt_um_jleugeri_ttt_event_fifo #(
  parameter int unsigned Width = 6,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
      if (i_push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/tt_um_jleugeri_ttt_host_driver.sv
// Host-side driver for the TTT main controller: turns a ready/valid event stream into
// read/advance instructions, follows the controller stage and buffers emitted tokens.
module tt_um_jleugeri_ttt_host_driver
  import tt_um_jleugeri_ttt_pkg::*;
#(
  parameter int unsigned NUM_PROCESSORS = 10,
  parameter int unsigned NEW_TOKEN_BITS = 4,
  parameter int unsigned OUT_DEPTH      = 8,
  parameter int unsigned TS_BITS        = 16
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    ev_valid,
  output logic                                    ev_ready,
  input  logic [$clog2(NUM_PROCESSORS)-1:0]       ev_processor_id,
  input  logic signed [NEW_TOKEN_BITS-1:0]        ev_good,
  input  logic signed [NEW_TOKEN_BITS-1:0]        ev_bad,
  input  logic                                    ev_nop,
  input  logic                                    ev_last,
  output logic [3:0]                              instruction,
  output logic [$clog2(NUM_PROCESSORS+1)-1:0]     processor_id,
  output logic signed [NEW_TOKEN_BITS-1:0]        good_tokens,
  output logic signed [NEW_TOKEN_BITS-1:0]        bad_tokens,
  input  logic [1:0]                              stage,
  input  logic [$clog2(NUM_PROCESSORS)-1:0]       proc_id_in,
  input  logic [1:0]                              startstop_in,
  input  logic                                    valid_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [$clog2(NUM_PROCESSORS)-1:0]       out_processor_id,
  output logic [1:0]                              out_startstop,
  output logic                                    step_done,
  output logic [TS_BITS-1:0]                      timestep,
  output logic                                    overflow
);

  localparam int unsigned PidW = $clog2(NUM_PROCESSORS);
  localparam int unsigned PinW = $clog2(NUM_PROCESSORS + 1);

  drv_state_t                 r_state, w_state_d;
  logic [3:0]                 r_instr, w_instr_d;
  logic [PinW-1:0]            r_proc_id, w_proc_id_d;
  logic [NEW_TOKEN_BITS-1:0]  r_good, w_good_d;
  logic [NEW_TOKEN_BITS-1:0]  r_bad, w_bad_d;
  logic                       r_ev_ready, w_ev_ready_d;
  logic [1:0]                 r_wait_cnt, w_wait_cnt_d;
  logic                       r_retried, w_retried_d;
  logic                       r_step_done, w_step_done_d;
  logic [TS_BITS-1:0]         r_timestep, w_timestep_d;
  stage_t                     w_stage;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_fifo_empty;
  logic [PidW+1:0]            w_fifo_data;

  assign w_stage  = stage_t'(stage);
  assign w_accept = ev_valid && r_ev_ready && (r_state == StFeed);
  assign w_push   = (r_state == StRun) && valid_in;

  always_comb begin
    w_state_d     = r_state;
    w_instr_d     = INSTR_BLOCK;
    w_proc_id_d   = r_proc_id;
    w_good_d      = r_good;
    w_bad_d       = r_bad;
    w_wait_cnt_d  = r_wait_cnt;
    w_retried_d   = r_retried;
    w_step_done_d = 1'b0;
    w_timestep_d  = r_timestep;

    unique case (r_state)
      StFeed: begin
        if (w_accept) begin
          if (!ev_nop) begin
            w_instr_d   = INSTR_READ;
            w_proc_id_d = PinW'(ev_processor_id);
            w_good_d    = ev_good;
            w_bad_d     = ev_bad;
          end
          if (ev_last) begin
            w_state_d   = StAdvance;
            w_retried_d = 1'b0;
          end
        end
      end
      StAdvance: begin
        w_instr_d    = INSTR_ADVANCE;
        w_state_d    = StWaitLeave;
        w_wait_cnt_d = '0;
      end
      StWaitLeave: begin
        if (w_stage != STAGE_INPUT) begin
          w_state_d = StRun;
        end else if (r_wait_cnt == 2'd3) begin
          // The controller never left the input stage: assume the advance edge was lost
          // and repeat it a single time.
          w_wait_cnt_d = '0;
          if (!r_retried) begin
            w_state_d   = StAdvance;
            w_retried_d = 1'b1;
          end
        end else begin
          w_wait_cnt_d = r_wait_cnt + 2'd1;
        end
      end
      StRun: begin
        if (w_stage == STAGE_INPUT) begin
          w_state_d     = StFeed;
          w_step_done_d = 1'b1;
          w_timestep_d  = r_timestep + TS_BITS'(1);
        end
      end
      default: w_state_d = StFeed;
    endcase

    w_ev_ready_d = (w_state_d == StFeed);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StFeed;
      r_instr     <= INSTR_BLOCK;
      r_proc_id   <= '0;
      r_good      <= '0;
      r_bad       <= '0;
      r_ev_ready  <= 1'b0;
      r_wait_cnt  <= '0;
      r_retried   <= 1'b0;
      r_step_done <= 1'b0;
      r_timestep  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_instr     <= w_instr_d;
      r_proc_id   <= w_proc_id_d;
      r_good      <= w_good_d;
      r_bad       <= w_bad_d;
      r_ev_ready  <= w_ev_ready_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_retried   <= w_retried_d;
      r_step_done <= w_step_done_d;
      r_timestep  <= w_timestep_d;
    end
  end

  tt_um_jleugeri_ttt_event_fifo #(
    .Width (PidW + 2),
    .Depth (OUT_DEPTH)
  ) u_event_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_data     ({proc_id_in, startstop_in}),
    .i_pop      (out_ready),
    .o_data     (w_fifo_data),
    .o_empty    (w_fifo_empty),
    .o_overflow (overflow)
  );

  assign ev_ready         = r_ev_ready;
  assign instruction      = r_instr;
  assign processor_id     = r_proc_id;
  assign good_tokens      = r_good;
  assign bad_tokens       = r_bad;
  assign step_done        = r_step_done;
  assign timestep         = r_timestep;
  assign out_valid        = !w_fifo_empty;
  assign out_processor_id = w_fifo_data[PidW+1:2];
  assign out_startstop    = w_fifo_data[1:0];

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_host_driver.sv
// Randomised scoreboard bench for the TTT host driver with a behavioural model of the
// main controller's stage sequencing and token emission.
module tb_tt_um_jleugeri_ttt_host_driver;
  import tt_um_jleugeri_ttt_pkg::*;

  localparam int NP  = 10;
  localparam int NTB = 4;
  localparam int OD  = 8;
  localparam int TSB = 4;
  localparam int PW  = $clog2(NP);
  localparam int PIW = $clog2(NP + 1);

  logic                   clk;
  logic                   reset_n;
  logic                   ev_valid, ev_ready, ev_nop, ev_last;
  logic [PW-1:0]          ev_processor_id;
  logic signed [NTB-1:0]  ev_good, ev_bad;
  logic [3:0]             instruction;
  logic [PIW-1:0]         processor_id;
  logic signed [NTB-1:0]  good_tokens, bad_tokens;
  logic [1:0]             stage;
  logic [PW-1:0]          proc_id_in;
  logic [1:0]             startstop_in;
  logic                   valid_in;
  logic                   out_valid, out_ready;
  logic [PW-1:0]          out_processor_id;
  logic [1:0]             out_startstop;
  logic                   step_done;
  logic [TSB-1:0]         timestep;
  logic                   overflow;

  tt_um_jleugeri_ttt_host_driver #(
    .NUM_PROCESSORS (NP),
    .NEW_TOKEN_BITS (NTB),
    .OUT_DEPTH      (OD),
    .TS_BITS        (TSB)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ev_valid         (ev_valid),
    .ev_ready         (ev_ready),
    .ev_processor_id  (ev_processor_id),
    .ev_good          (ev_good),
    .ev_bad           (ev_bad),
    .ev_nop           (ev_nop),
    .ev_last          (ev_last),
    .instruction      (instruction),
    .processor_id     (processor_id),
    .good_tokens      (good_tokens),
    .bad_tokens       (bad_tokens),
    .stage            (stage),
    .proc_id_in       (proc_id_in),
    .startstop_in     (startstop_in),
    .valid_in         (valid_in),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_processor_id (out_processor_id),
    .out_startstop    (out_startstop),
    .step_done        (step_done),
    .timestep         (timestep),
    .overflow         (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [PW-1:0]  id;
    logic [NTB-1:0] good;
    logic [NTB-1:0] bad;
    logic           nop;
    logic           last;
  } ev_t;

  typedef struct {
    logic [3:0]     instr;
    logic [PIW-1:0] id;
    logic [NTB-1:0] good;
    logic [NTB-1:0] bad;
  } instr_t;

  typedef struct {
    logic [PW-1:0] id;
    logic [1:0]    ss;
  } oev_t;

  int     checks = 0;
  int     passes = 0;
  instr_t exp_instr[$];
  oev_t   scan_q[$];
  oev_t   exp_out[$];
  int     ref_cnt = 0;
  bit     exp_overflow = 0;
  int     ctrl_done = 0;
  int     rst_base = 0;
  int     steps_seen = 0;
  int     rmode = 1;  // 0: stall, 1: always ready, 2: random

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string msg);
    checks++;
    $display("FAIL %s", msg);
  endtask

  // Host output readiness.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = (rmode == 1) || (rmode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  // Main controller model: on an advance it spends NP+1 cycles in update, then scans
  // (emitting queued tokens one per cycle), routes, and returns to the input stage.
  task automatic ctrl_tick(output bit ab);
    @(posedge clk); #1;
    ab = !reset_n;
    if (ab) begin
      stage    = 2'b00;
      valid_in = 1'b0;
    end
  endtask

  task automatic run_step();
    oev_t evs[$];
    bit   ab;
    evs = scan_q;
    scan_q.delete();
    ctrl_tick(ab); if (ab) return;
    stage = 2'b01;
    for (int i = 0; i < NP + 1; i++) begin
      ctrl_tick(ab); if (ab) return;
    end
    stage = 2'b10;
    foreach (evs[i]) begin
      valid_in     = 1'b1;
      proc_id_in   = evs[i].id;
      startstop_in = evs[i].ss;
      ctrl_tick(ab); if (ab) return;
    end
    valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ctrl_tick(ab); if (ab) return;
    end
    stage = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ctrl_tick(ab); if (ab) return;
    end
    stage = 2'b00;
    ctrl_done++;
  endtask

  initial begin
    stage = 2'b00; valid_in = 1'b0; proc_id_in = '0; startstop_in = '0;
    forever begin
      @(negedge clk);
      if (reset_n && instruction == INSTR_ADVANCE) run_step();
    end
  end

  // Reference output queue: capacity OD, drop when full with no concurrent pop.
  always @(negedge clk) begin : ref_fifo
    bit pop;
    if (!reset_n) begin
      ref_cnt = 0;
      exp_out.delete();
      exp_overflow = 0;
    end else begin
      check("out_valid", out_valid, ref_cnt != 0);
      pop = (ref_cnt != 0) && out_ready;
      if (pop) ref_cnt--;
      if (valid_in) begin
        if (ref_cnt == OD) exp_overflow = 1;
        else begin
          ref_cnt++;
          exp_out.push_back('{proc_id_in, startstop_in});
        end
      end
    end
  end

  always @(negedge clk) begin : out_mon
    oev_t e;
    if (reset_n && out_valid && out_ready) begin
      if (exp_out.size() == 0) fail($sformatf("out_unexpected id=%0d ss=%b",
                                              out_processor_id, out_startstop));
      else begin
        e = exp_out.pop_front();
        check("out_event", {out_processor_id, out_startstop}, {e.id, e.ss});
      end
    end
  end

  always @(negedge clk) begin : instr_mon
    instr_t e;
    if (reset_n && instruction != INSTR_BLOCK) begin
      if (exp_instr.size() == 0) fail($sformatf("instr_unexpected got %b", instruction));
      else begin
        e = exp_instr.pop_front();
        if (e.instr == INSTR_ADVANCE) check("instr_advance", instruction, e.instr);
        else check("instr_read", {instruction, processor_id, good_tokens, bad_tokens},
                   {e.instr, e.id, e.good, e.bad});
      end
    end
  end

  always @(negedge clk) begin : step_mon
    if (!reset_n) begin
      rst_base   = ctrl_done;
      steps_seen = 0;
    end else if (step_done) begin
      steps_seen++;
      check("step_done_count", steps_seen, ctrl_done - rst_base);
      check("timestep", timestep, (ctrl_done - rst_base) % (1 << TSB));
      check("instr_drained", exp_instr.size(), 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input ev_t ev);
    instr_t e;
    bit     ok;
    ok = 0;
    ev_valid = 1'b1; ev_processor_id = ev.id; ev_good = ev.good; ev_bad = ev.bad;
    ev_nop = ev.nop; ev_last = ev.last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ev_ready) begin ok = 1; break; end
    end
    if (!ok) fail("ev_accept_timeout");
    else begin
      if (!ev.nop) begin
        e.instr = INSTR_READ; e.id = PIW'(ev.id); e.good = ev.good; e.bad = ev.bad;
        exp_instr.push_back(e);
      end
      if (ev.last) begin
        e.instr = INSTR_ADVANCE; e.id = '0; e.good = '0; e.bad = '0;
        exp_instr.push_back(e);
      end
    end
    @(posedge clk); #1;
    ev_valid = 1'b0;
  endtask

  task automatic run_timestep(input ev_t evs[$], input oev_t scans[$]);
    bit ok;
    scan_q = scans;
    foreach (evs[i]) send(evs[i]);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (step_done) begin ok = 1; break; end
    end
    if (!ok) fail("step_done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic random_step();
    ev_t  evs[$];
    oev_t sc[$];
    ev_t  ev;
    oev_t o;
    int   n;
    n = $urandom_range(0, 4);
    for (int i = 0; i <= n; i++) begin
      ev.id   = PW'($urandom_range(0, NP - 1));
      ev.good = NTB'($urandom_range(0, 15));
      ev.bad  = NTB'($urandom_range(0, 15));
      ev.nop  = ($urandom_range(0, 4) == 0);
      ev.last = (i == n);
      evs.push_back(ev);
    end
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) begin
      o.id = PW'($urandom_range(0, NP - 1));
      o.ss = $urandom_range(0, 1) == 1 ? SS_START : SS_STOP;
      sc.push_back(o);
    end
    run_timestep(evs, sc);
  endtask

  task automatic drain();
    rmode = 1;
    for (int t = 0; t < 100 && ref_cnt != 0; t++) @(negedge clk);
    @(posedge clk); #1;
    check("drain_empty", out_valid, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    ev_t  evs[$];
    oev_t sc[$];
    bit   ok;
    reset_n = 1'b0; ev_valid = 1'b0; ev_processor_id = '0; ev_good = '0; ev_bad = '0;
    ev_nop = 1'b0; ev_last = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_instruction", instruction, INSTR_BLOCK);
    check("rst_processor_id", processor_id, 0);
    check("rst_tokens", {good_tokens, bad_tokens}, 0);
    check("rst_ev_ready", ev_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_step_done", step_done, 0);
    check("rst_timestep", timestep, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ev_ready_after_release", ev_ready, 1);

    // Three reads then an empty last event; two scan tokens.
    evs = '{'{PW'(2), NTB'(3), NTB'(1), 1'b0, 1'b0},
            '{PW'(5), NTB'(-1), NTB'(6), 1'b0, 1'b0},
            '{PW'(7), NTB'(4), NTB'(-2), 1'b0, 1'b0},
            '{PW'(0), NTB'(0), NTB'(0), 1'b1, 1'b1}};
    sc  = '{'{PW'(1), SS_START}, '{PW'(4), SS_STOP}};
    run_timestep(evs, sc);
    check("timestep_after_a", timestep, 1);

    // Empty timestep.
    evs = '{'{PW'(0), NTB'(0), NTB'(0), 1'b1, 1'b1}};
    sc.delete();
    run_timestep(evs, sc);
    check("timestep_after_b", timestep, 2);

    // Host stalls while nine tokens arrive: one must be dropped.
    rmode = 0;
    sc.delete();
    for (int i = 0; i < 9; i++) sc.push_back('{PW'(i), (i % 2 == 0) ? SS_START : SS_STOP});
    evs = '{'{PW'(3), NTB'(2), NTB'(2), 1'b0, 1'b1}};
    run_timestep(evs, sc);
    check("overflow_set", overflow, 1);
    check("overflow_model", overflow, exp_overflow);
    rmode = 2;
    random_step();
    check("overflow_sticky", overflow, 1);
    drain();

    // Reset in the middle of a scan with tokens buffered.
    rmode = 0;
    sc = '{'{PW'(6), SS_START}, '{PW'(8), SS_STOP}, '{PW'(9), SS_START}};
    scan_q = sc;
    send('{PW'(1), NTB'(5), NTB'(0), 1'b0, 1'b1});
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (stage == 2'b10) begin ok = 1; break; end
    end
    if (!ok) fail("scan_stage_timeout");
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_instruction", instruction, INSTR_BLOCK);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ev_ready", ev_ready, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_timestep", timestep, 0);
    exp_instr.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_feed_ready", ev_ready, 1);
    rmode = 2;

    // Enough steps to wrap the 4-bit timestep counter.
    for (int s = 0; s < 16; s++) begin
      rmode = $urandom_range(1, 2);
      random_step();
    end
    check("timestep_wrapped", timestep, 0);
    random_step();
    check("timestep_after_wrap", timestep, 1);
    drain();
    check("final_overflow", overflow, exp_overflow);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
